// File: rtl/mips_ctr_unit_if.sv
// Decode bundle between the instruction source and the MIPS control decoder.
// The master drives op/func; the slave returns control signals and the halted flag.
interface mips_ctr_unit_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       memread;
   logic       memwrite;
   logic       alusrc;
   logic       memtoreg;
   logic       regdst;
   logic       regwrite;
   logic       jump;
   logic       branch;
   logic       bneorbeq;
   logic       isjal;
   logic       zeroextend;
   logic       readrs;
   logic       readrt;
   logic       issyscall;
   logic       isjr;
   logic       isshamt;
   logic       iscop0;
   logic [3:0] aluop;
   logic       halted;

   modport master (
      output op, func,
      input  memread, memwrite, alusrc, memtoreg, regdst, regwrite, jump, branch,
             bneorbeq, isjal, zeroextend, readrs, readrt, issyscall, isjr, isshamt,
             iscop0, aluop, halted
   );

   modport slave (
      input  op, func,
      output memread, memwrite, alusrc, memtoreg, regdst, regwrite, jump, branch,
             bneorbeq, isjal, zeroextend, readrs, readrt, issyscall, isjr, isshamt,
             iscop0, aluop, halted
   );
endinterface

// File: rtl/mips_ctr_unit.sv
// Single-cycle MIPS main decoder: op/func -> datapath controls, zero-cycle combinational.
// No backpressure; only the sticky halted flag is registered (set by a retiring SYSCALL).
module mips_ctr_unit (
   input logic            clk,
   input logic            rst_n,
   mips_ctr_unit_if.slave bus
);
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_NOR  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b1011;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       alusrc;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       jump;
      logic       branch;
      logic       bneorbeq;
      logic       isjal;
      logic       zeroextend;
      logic       readrs;
      logic       readrt;
      logic       issyscall;
      logic       isjr;
      logic       isshamt;
      logic       iscop0;
      logic [3:0] aluop;
   } ctrl_t;

   ctrl_t ctrl;
   logic  halted_d;
   logic  halted_q;

   always_comb begin
      ctrl = '0;
      case (bus.op)
         6'b000000: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.readrs   = 1'b1;
            ctrl.readrt   = 1'b1;
            case (bus.func)
               6'b100000, 6'b100001: ctrl.aluop = ALU_ADD;
               6'b100010, 6'b100011: ctrl.aluop = ALU_SUB;
               6'b100100:            ctrl.aluop = ALU_AND;
               6'b100101:            ctrl.aluop = ALU_OR;
               6'b100110:            ctrl.aluop = ALU_XOR;
               6'b100111:            ctrl.aluop = ALU_NOR;
               6'b101010:            ctrl.aluop = ALU_SLT;
               6'b101011:            ctrl.aluop = ALU_SLTU;
               6'b000100:            ctrl.aluop = ALU_SLL;
               6'b000110:            ctrl.aluop = ALU_SRL;
               6'b000111:            ctrl.aluop = ALU_SRA;
               // Constant shifts take their amount from shamt, so rs is not a source.
               6'b000000, 6'b000010, 6'b000011: begin
                  ctrl.isshamt = 1'b1;
                  ctrl.readrs  = 1'b0;
                  ctrl.aluop   = (bus.func == 6'b000000) ? ALU_SLL :
                                 (bus.func == 6'b000010) ? ALU_SRL : ALU_SRA;
               end
               6'b001000: begin
                  ctrl        = '0;
                  ctrl.isjr   = 1'b1;
                  ctrl.readrs = 1'b1;
               end
               6'b001100: begin
                  ctrl           = '0;
                  ctrl.issyscall = 1'b1;
                  ctrl.readrs    = 1'b1;
                  ctrl.readrt    = 1'b1;
               end
               default: ctrl = '0;
            endcase
         end
         6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.readrs   = 1'b1;
            ctrl.aluop    = (bus.op == 6'b001010) ? ALU_SLT :
                            (bus.op == 6'b001011) ? ALU_SLTU : ALU_ADD;
         end
         6'b001100, 6'b001101, 6'b001110: begin
            ctrl.alusrc     = 1'b1;
            ctrl.regwrite   = 1'b1;
            ctrl.readrs     = 1'b1;
            ctrl.zeroextend = 1'b1;
            ctrl.aluop      = (bus.op == 6'b001100) ? ALU_AND :
                              (bus.op == 6'b001101) ? ALU_OR : ALU_XOR;
         end
         6'b001111: begin
            ctrl.alusrc     = 1'b1;
            ctrl.regwrite   = 1'b1;
            ctrl.zeroextend = 1'b1;
            ctrl.aluop      = ALU_LUI;
         end
         6'b100011: begin
            ctrl.memread  = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.readrs   = 1'b1;
            ctrl.aluop    = ALU_ADD;
         end
         6'b101011: begin
            ctrl.memwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.readrs   = 1'b1;
            ctrl.readrt   = 1'b1;
            ctrl.aluop    = ALU_ADD;
         end
         6'b000100, 6'b000101: begin
            ctrl.branch   = 1'b1;
            ctrl.readrs   = 1'b1;
            ctrl.readrt   = 1'b1;
            ctrl.bneorbeq = bus.op[0];
            ctrl.aluop    = ALU_SUB;
         end
         6'b000010: ctrl.jump = 1'b1;
         // JAL leaves regdst low; the datapath steers the write to $31.
         6'b000011: begin
            ctrl.jump     = 1'b1;
            ctrl.isjal    = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         6'b010000: ctrl.iscop0 = 1'b1;
         default:   ctrl = '0;
      endcase
   end

   always_comb begin
      halted_d = halted_q | ctrl.issyscall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign bus.memread    = ctrl.memread;
   assign bus.memwrite   = ctrl.memwrite;
   assign bus.alusrc     = ctrl.alusrc;
   assign bus.memtoreg   = ctrl.memtoreg;
   assign bus.regdst     = ctrl.regdst;
   assign bus.regwrite   = ctrl.regwrite;
   assign bus.jump       = ctrl.jump;
   assign bus.branch     = ctrl.branch;
   assign bus.bneorbeq   = ctrl.bneorbeq;
   assign bus.isjal      = ctrl.isjal;
   assign bus.zeroextend = ctrl.zeroextend;
   assign bus.readrs     = ctrl.readrs;
   assign bus.readrt     = ctrl.readrt;
   assign bus.issyscall  = ctrl.issyscall;
   assign bus.isjr       = ctrl.isjr;
   assign bus.isshamt    = ctrl.isshamt;
   assign bus.iscop0     = ctrl.iscop0;
   assign bus.aluop      = ctrl.aluop;
   assign bus.halted     = halted_q;
endmodule

// File: tb/tb_mips_ctr_unit.sv
// Directed bench for mips_ctr_unit: expected control vectors are queued per stimulus
// and compared against the full decoded output vector.
module tb_mips_ctr_unit;
   localparam logic [17:0] F_MR  = 18'd1 << 17;
   localparam logic [17:0] F_MW  = 18'd1 << 16;
   localparam logic [17:0] F_AS  = 18'd1 << 15;
   localparam logic [17:0] F_M2R = 18'd1 << 14;
   localparam logic [17:0] F_RD  = 18'd1 << 13;
   localparam logic [17:0] F_RW  = 18'd1 << 12;
   localparam logic [17:0] F_J   = 18'd1 << 11;
   localparam logic [17:0] F_BR  = 18'd1 << 10;
   localparam logic [17:0] F_BNE = 18'd1 << 9;
   localparam logic [17:0] F_JAL = 18'd1 << 8;
   localparam logic [17:0] F_ZX  = 18'd1 << 7;
   localparam logic [17:0] F_RS  = 18'd1 << 6;
   localparam logic [17:0] F_RT  = 18'd1 << 5;
   localparam logic [17:0] F_SYS = 18'd1 << 4;
   localparam logic [17:0] F_JR  = 18'd1 << 3;
   localparam logic [17:0] F_SH  = 18'd1 << 2;
   localparam logic [17:0] F_C0  = 18'd1 << 1;
   localparam logic [17:0] F_HLT = 18'd1 << 0;

   localparam logic [17:0] F_RTYPE = F_RD | F_RW | F_RS | F_RT;
   localparam logic [17:0] F_LW    = F_MR | F_M2R | F_AS | F_RW | F_RS;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [21:0] sb[$];

   mips_ctr_unit_if bus_if ();

   mips_ctr_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [21:0] observed();
      return {bus_if.memread, bus_if.memwrite, bus_if.alusrc, bus_if.memtoreg,
              bus_if.regdst, bus_if.regwrite, bus_if.jump, bus_if.branch,
              bus_if.bneorbeq, bus_if.isjal, bus_if.zeroextend, bus_if.readrs,
              bus_if.readrt, bus_if.issyscall, bus_if.isjr, bus_if.isshamt,
              bus_if.iscop0, bus_if.halted, bus_if.aluop};
   endfunction

   task automatic check(input string tag);
      logic [21:0] exp_v;
      logic [21:0] obs_v;
      n_checks++;
      if (sb.size() == 0) begin
         $error("FAIL %s: scoreboard empty, observed %h", tag, observed());
      end else begin
         exp_v = sb.pop_front();
         obs_v = observed();
         assert (obs_v === exp_v) n_pass++;
         else $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
      end
   endtask

   task automatic step(input logic [5:0] o, input logic [5:0] f,
                       input logic [17:0] fl, input logic [3:0] al, input string tag);
      @(negedge clk);
      bus_if.op   = o;
      bus_if.func = f;
      sb.push_back({fl, al});
      #1;
      check(tag);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus_if.op   = 6'b111111;
      bus_if.func = 6'b000000;
      #1;
      sb.push_back(22'd0);
      check("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      step(6'b000000, 6'b100000, F_RTYPE,                 4'b0000, "r_add");
      step(6'b000000, 6'b001000, F_JR | F_RS,             4'b0000, "r_jr");
      step(6'b000000, 6'b100011, F_RTYPE,                 4'b0001, "r_subu");
      step(6'b000000, 6'b100111, F_RTYPE,                 4'b0101, "r_nor");
      step(6'b000000, 6'b101011, F_RTYPE,                 4'b0111, "r_sltu");
      step(6'b000000, 6'b000000, F_RD | F_RW | F_RT | F_SH, 4'b1000, "r_sll");
      step(6'b000000, 6'b000011, F_RD | F_RW | F_RT | F_SH, 4'b1010, "r_sra");
      step(6'b000000, 6'b000110, F_RTYPE,                 4'b1001, "r_srlv");
      step(6'b000000, 6'b111111, 18'd0,                   4'b0000, "r_unknown");

      // SYSCALL decode, sticky halt, then asynchronous clear.
      step(6'b000000, 6'b001100, F_SYS | F_RS | F_RT,     4'b0000, "syscall_decode");
      @(posedge clk);
      #1;
      sb.push_back({F_SYS | F_RS | F_RT | F_HLT, 4'b0000});
      check("halted_set");
      step(6'b100011, 6'b000000, F_LW | F_HLT,            4'b0000, "halted_sticky");
      #2;
      rst_n = 1'b0;
      #1;
      sb.push_back({F_LW, 4'b0000});
      check("halted_async_clear");
      @(negedge clk);
      rst_n = 1'b1;

      step(6'b100011, 6'b000000, F_LW,                         4'b0000, "lw");
      step(6'b101011, 6'b000000, F_MW | F_AS | F_RS | F_RT,    4'b0000, "sw");
      step(6'b001000, 6'b000000, F_AS | F_RW | F_RS,           4'b0000, "addi");
      step(6'b001011, 6'b000000, F_AS | F_RW | F_RS,           4'b0111, "sltiu");
      step(6'b001101, 6'b000000, F_AS | F_RW | F_RS | F_ZX,    4'b0011, "ori");
      step(6'b001111, 6'b000000, F_AS | F_RW | F_ZX,           4'b1011, "lui");
      step(6'b000010, 6'b000000, F_J,                          4'b0000, "j");
      step(6'b000011, 6'b000000, F_J | F_JAL | F_RW,           4'b0000, "jal");
      step(6'b000100, 6'b000000, F_BR | F_RS | F_RT,           4'b0001, "beq");
      step(6'b000101, 6'b000000, F_BR | F_BNE | F_RS | F_RT,   4'b0001, "bne");
      step(6'b010000, 6'b001100, F_C0,                         4'b0000, "cop0");
      step(6'b111111, 6'b001100, 18'd0,                        4'b0000, "illegal_op");

      // No SYSCALL was presented since the reset release.
      @(posedge clk);
      #1;
      sb.push_back(22'd0);
      check("halted_stays_clear");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
